// File: rtl/data_mem_master.sv
// Client-to-RAM master: single-word writes and 1-4 beat read bursts against a
// synchronous single-port RAM, with address range checking and one response per beat.
module data_mem_master (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [1:0]  req_len,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_last,
   output logic        rsp_err,
   output logic [11:0] ram_address,
   output logic [15:0] ram_write_data,
   input  logic [15:0] ram_read_data,
   output logic        ram_read_not_write,
   output logic        ram_cs,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RD_ISSUE   = 3'd1,
      RD_CAPTURE = 3'd2,
      WR_ISSUE   = 3'd3,
      ERR_RSP    = 3'd4
   } state_t;

   state_t      r_state;
   logic [11:0] r_addr;
   logic [1:0]  r_cnt;
   logic        r_rsp_valid;
   logic [15:0] r_rsp_rdata;
   logic        r_rsp_last;
   logic        r_rsp_err;
   logic [11:0] r_ram_address;
   logic [15:0] r_ram_write_data;
   logic        r_ram_rnw;
   logic        r_ram_cs;
   logic        w_accept;

   // Handshake: a request transfers on the rising edge where req_valid && req_ready;
   // req_ready is high only while idle. Responses are single-cycle pulses with no backpressure.
   assign req_ready = (r_state == IDLE);
   assign w_accept  = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= IDLE;
         r_addr           <= '0;
         r_cnt            <= '0;
         r_rsp_valid      <= 1'b0;
         r_rsp_rdata      <= '0;
         r_rsp_last       <= 1'b0;
         r_rsp_err        <= 1'b0;
         r_ram_address    <= '0;
         r_ram_write_data <= '0;
         r_ram_rnw        <= 1'b1;
         r_ram_cs         <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (req_addr[15:12] != 4'd0) begin
                     r_state     <= ERR_RSP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_last  <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else if (req_write) begin
                     r_state          <= WR_ISSUE;
                     r_ram_cs         <= 1'b1;
                     r_ram_rnw        <= 1'b0;
                     r_ram_address    <= req_addr[11:0];
                     r_ram_write_data <= req_wdata;
                  end else begin
                     r_state       <= RD_ISSUE;
                     r_ram_cs      <= 1'b1;
                     r_ram_rnw     <= 1'b1;
                     r_ram_address <= req_addr[11:0];
                     r_addr        <= req_addr[11:0];
                     r_cnt         <= req_len;
                  end
               end
            end
            RD_ISSUE: begin
               r_ram_cs <= 1'b0;
               r_state  <= RD_CAPTURE;
            end
            RD_CAPTURE: begin
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= ram_read_data;
               r_rsp_last  <= (r_cnt == 2'd0);
               if (r_cnt == 2'd0) begin
                  r_state <= IDLE;
               end else begin
                  // 12-bit address wraps 0xFFF -> 0x000 naturally
                  r_cnt         <= r_cnt - 2'd1;
                  r_addr        <= r_addr + 12'd1;
                  r_ram_address <= r_addr + 12'd1;
                  r_ram_cs      <= 1'b1;
                  r_state       <= RD_ISSUE;
               end
            end
            WR_ISSUE: begin
               r_ram_cs    <= 1'b0;
               r_ram_rnw   <= 1'b1;
               r_rsp_valid <= 1'b1;
               r_rsp_last  <= 1'b1;
               r_rsp_rdata <= '0;
               r_state     <= IDLE;
            end
            ERR_RSP: begin
               r_state <= IDLE;
            end
            default: begin
               r_ram_cs  <= 1'b0;
               r_ram_rnw <= 1'b1;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid          = r_rsp_valid;
   assign rsp_rdata          = r_rsp_rdata;
   assign rsp_last           = r_rsp_last;
   assign rsp_err            = r_rsp_err;
   assign ram_address        = r_ram_address;
   assign ram_write_data     = r_ram_write_data;
   assign ram_read_not_write = r_ram_rnw;
   assign ram_cs             = r_ram_cs;
   assign dbg_state          = r_state;

endmodule

// File: tb/tb_data_mem_master.sv
// Bench for data_mem_master: behavioural RAM, response scoreboard queue, per-scenario tasks.
module tb_data_mem_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0]  req_len = '0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_last;
   logic        rsp_err;
   logic [11:0] ram_address;
   logic [15:0] ram_write_data;
   logic [15:0] ram_read_data = '0;
   logic        ram_read_not_write;
   logic        ram_cs;
   logic [2:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   // scoreboard entry: {err, last, rdata}
   logic [17:0] exp_q[$];

   logic [15:0] mem [0:4095];
   int          cs_count = 0;
   int          cs_viol = 0;
   logic        cs_prev = 1'b0;
   logic [11:0] cs_addr_q[$];
   logic        cs_rnw_last = 1'b1;
   logic [15:0] cs_wdata_last = '0;

   data_mem_master dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .ram_address(ram_address), .ram_write_data(ram_write_data),
      .ram_read_data(ram_read_data), .ram_read_not_write(ram_read_not_write),
      .ram_cs(ram_cs), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Synchronous RAM model plus chip-select activity monitor
   always @(posedge clk) begin
      if (ram_cs) begin
         cs_count++;
         cs_addr_q.push_back(ram_address);
         cs_rnw_last = ram_read_not_write;
         cs_wdata_last = ram_write_data;
         if (!ram_read_not_write) mem[ram_address] <= ram_write_data;
         else ram_read_data <= mem[ram_address];
      end
      if (ram_cs && cs_prev) cs_viol++;
      cs_prev <= ram_cs;
   end

   task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] l);
      req_write = w; req_addr = a; req_wdata = d; req_len = l; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Waits (bounded) for a response; lat counts negedges since the acceptance edge.
   task automatic collect(output logic got, output logic [17:0] rsp, output int lat);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      got = rsp_valid;
      rsp = {rsp_err, rsp_last, rsp_rdata};
   endtask

   task automatic pop_exp(output logic [17:0] e);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 18'h3FFFF;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      checks++; if ({rsp_valid, rsp_last, rsp_err} !== 3'b000) begin errors++; $display("FAIL reset_rsp got %b exp 000", {rsp_valid, rsp_last, rsp_err}); end
      checks++; if ({ram_cs, ram_read_not_write} !== 2'b01) begin errors++; $display("FAIL reset_ram_ctl got %b exp 01", {ram_cs, ram_read_not_write}); end
      checks++; if ({ram_address, ram_write_data, rsp_rdata} !== 44'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {ram_address, ram_write_data, rsp_rdata}); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({req_ready, rsp_valid, ram_cs} !== 3'b100) begin errors++; $display("FAIL post_reset got %b exp 100", {req_ready, rsp_valid, ram_cs}); end
   endtask

   task automatic test_write;
      logic got; logic [17:0] r, e; int lat; int c0;
      c0 = cs_count;
      exp_q.push_back({1'b0, 1'b1, 16'h0000});
      send(1'b1, 16'h0010, 16'hBEEF, 2'd0);
      collect(got, r, lat);
      pop_exp(e);
      checks++; if (got !== 1'b1 || r !== e) begin errors++; $display("FAIL write_rsp got %b/%h exp 1/%h", got, r, e); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency got %0d exp 2", lat); end
      checks++; if (cs_count - c0 !== 1) begin errors++; $display("FAIL write_cs_count got %0d exp 1", cs_count - c0); end
      checks++; if (cs_addr_q.size() == 0 || cs_addr_q[$] !== 12'h010 || cs_rnw_last !== 1'b0 || cs_wdata_last !== 16'hBEEF) begin
         errors++; $display("FAIL write_ram_access got rnw %b data %h exp 0 BEEF", cs_rnw_last, cs_wdata_last); end
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_last} !== 2'b00) begin errors++; $display("FAIL write_pulse_width got %b exp 00", {rsp_valid, rsp_last}); end
   endtask

   task automatic test_read_single;
      logic got; logic [17:0] r, e; int lat;
      exp_q.push_back({1'b0, 1'b1, 16'hBEEF});
      send(1'b0, 16'h0010, 16'h0000, 2'd0);
      collect(got, r, lat);
      pop_exp(e);
      checks++; if (got !== 1'b1 || r !== e) begin errors++; $display("FAIL read_single got %b/%h exp 1/%h", got, r, e); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency got %0d exp 3", lat); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL read_hold got %b/%h exp 0/BEEF", rsp_valid, rsp_rdata); end
   endtask

   task automatic test_wrap_burst;
      logic got; logic [17:0] r, e; int lat;
      logic [11:0] pa [4];
      logic [15:0] pd [4];
      pa[0] = 12'hFFE; pa[1] = 12'hFFF; pa[2] = 12'h000; pa[3] = 12'h001;
      pd[0] = 16'h1111; pd[1] = 16'h2222; pd[2] = 16'h3333; pd[3] = 16'h4444;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, 1'b1, 16'h0000});
         send(1'b1, {4'h0, pa[i]}, pd[i], 2'd0);
         collect(got, r, lat);
         pop_exp(e);
         checks++; if (got !== 1'b1 || r !== e) begin errors++; $display("FAIL preload_%0d got %b/%h exp 1/%h", i, got, r, e); end
         @(negedge clk);
      end
      cs_addr_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, (i == 3), pd[i]});
      send(1'b0, 16'h0FFE, 16'h0000, 2'd3);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         collect(got, r, lat);
         pop_exp(e);
         checks++; if (got !== 1'b1 || r !== e) begin errors++; $display("FAIL burst_beat_%0d got %b/%h exp 1/%h", i, got, r, e); end
         checks++; if (lat !== ((i == 0) ? 3 : 2)) begin errors++; $display("FAIL burst_spacing_%0d got %0d exp %0d", i, lat, (i == 0) ? 3 : 2); end
      end
      checks++; if (cs_addr_q.size() != 4) begin errors++; $display("FAIL burst_cs_count got %0d exp 4", cs_addr_q.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (cs_addr_q[i] !== pa[i]) begin errors++; $display("FAIL burst_addr_%0d got %h exp %h", i, cs_addr_q[i], pa[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_error;
      logic got; logic [17:0] r, e; int lat; int c0;
      for (int i = 0; i < 2; i++) begin
         c0 = cs_count;
         exp_q.push_back({1'b1, 1'b1, 16'h0000});
         send(1'b0, (i == 0) ? 16'h1000 : 16'($urandom_range(16'h1000, 16'hFFFF)), 16'h5A5A, 2'd3);
         collect(got, r, lat);
         pop_exp(e);
         checks++; if (got !== 1'b1 || r !== e) begin errors++; $display("FAIL error_rsp_%0d got %b/%h exp 1/%h", i, got, r, e); end
         checks++; if (lat !== 1) begin errors++; $display("FAIL error_latency_%0d got %0d exp 1", i, lat); end
         @(negedge clk);
         checks++; if (cs_count !== c0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL error_no_ram_%0d got cs %0d valid %b exp 0 0", i, cs_count - c0, rsp_valid); end
      end
   endtask

   task automatic test_back_to_back;
      logic got; logic [17:0] r, e; int lat;
      exp_q.push_back({1'b0, 1'b1, 16'h0000});
      send(1'b1, 16'h0123, 16'hC0DE, 2'd0);
      collect(got, r, lat);
      pop_exp(e);
      checks++; if (got !== 1'b1 || r !== e) begin errors++; $display("FAIL b2b_write got %b/%h exp 1/%h", got, r, e); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", req_ready); end
      exp_q.push_back({1'b0, 1'b1, 16'hC0DE});
      send(1'b0, 16'h0123, 16'h0000, 2'd0);
      collect(got, r, lat);
      pop_exp(e);
      checks++; if (got !== 1'b1 || r !== e || lat !== 3) begin errors++; $display("FAIL b2b_read got %b/%h lat %0d exp 1/%h lat 3", got, r, lat, e); end
      @(negedge clk);
   endtask

   task automatic test_random;
      logic got; logic [17:0] r, e; int lat;
      logic [15:0] ra [6];
      logic [15:0] rd [6];
      for (int i = 0; i < 6; i++) begin
         ra[i] = 16'(i * 600 + $urandom_range(0, 500));
         rd[i] = 16'($urandom);
         exp_q.push_back({1'b0, 1'b1, 16'h0000});
         send(1'b1, ra[i], rd[i], 2'($urandom_range(0, 3)));
         collect(got, r, lat);
         pop_exp(e);
         checks++; if (got !== 1'b1 || r !== e) begin errors++; $display("FAIL rand_write_%0d got %b/%h exp 1/%h", i, got, r, e); end
         @(negedge clk);
      end
      for (int i = 5; i >= 0; i--) begin
         exp_q.push_back({1'b0, 1'b1, rd[i]});
         send(1'b0, ra[i], 16'($urandom), 2'd0);
         collect(got, r, lat);
         pop_exp(e);
         checks++; if (got !== 1'b1 || r !== e) begin errors++; $display("FAIL rand_read_%0d got %b/%h exp 1/%h", i, got, r, e); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_burst;
      logic got; logic [17:0] r, e; int lat; int stray;
      exp_q.push_back({1'b0, 1'b0, 16'h1111});
      exp_q.push_back({1'b0, 1'b0, 16'h2222});
      exp_q.push_back({1'b0, 1'b0, 16'h3333});
      exp_q.push_back({1'b0, 1'b1, 16'h4444});
      send(1'b0, 16'h0FFE, 16'h0000, 2'd3);
      collect(got, r, lat);
      pop_exp(e);
      checks++; if (got !== 1'b1 || r !== e) begin errors++; $display("FAIL abort_first_beat got %b/%h exp 1/%h", got, r, e); end
      checks++; if (ram_cs !== 1'b1) begin errors++; $display("FAIL abort_second_issue got %b exp 1", ram_cs); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({ram_cs, req_ready, rsp_valid} !== 3'b010) begin errors++; $display("FAIL abort_async got %b exp 010", {ram_cs, req_ready, rsp_valid}); end
      exp_q.delete();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL abort_stray_rsp got %0d exp 0", stray); end
      exp_q.push_back({1'b0, 1'b1, 16'h0000});
      send(1'b1, 16'h0020, 16'h1234, 2'd0);
      collect(got, r, lat);
      pop_exp(e);
      checks++; if (got !== 1'b1 || r !== e || lat !== 2) begin errors++; $display("FAIL abort_then_write got %b/%h lat %0d exp 1/%h lat 2", got, r, lat, e); end
      @(negedge clk);
      exp_q.push_back({1'b0, 1'b1, 16'h1234});
      send(1'b0, 16'h0020, 16'h0000, 2'd0);
      collect(got, r, lat);
      pop_exp(e);
      checks++; if (got !== 1'b1 || r !== e) begin errors++; $display("FAIL abort_then_read got %b/%h exp 1/%h", got, r, e); end
      @(negedge clk);
   endtask

   task automatic test_cs_rule;
      checks++; if (cs_viol !== 0) begin errors++; $display("FAIL cs_consecutive got %0d exp 0", cs_viol); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_single();
      test_wrap_burst();
      test_error();
      test_back_to_back();
      test_random();
      test_reset_mid_burst();
      test_cs_rule();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
